// File: rtl/adc_sample_scheduler_if.sv
`timescale 1ns/1ps
// ADC-interface command/ready bus plus the valid/ready result port of the sample scheduler.
// The master modport is the scheduler side; the slave side is the ADC interface and the consumer.
interface adc_sample_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic             adc_cs;
  logic [3:0]       adc_op;
  logic [7:0]       adc_addr;
  logic             adc_rdy;
  logic [13:0]      adc_data;
  logic             res_valid;
  logic             res_ready;
  logic [13:0]      res_a;
  logic [13:0]      res_b;
  logic [CNT_W-1:0] res_idx;

  modport master (
    output adc_cs, adc_op, adc_addr, res_valid, res_a, res_b, res_idx,
    input  adc_rdy, adc_data, res_ready
  );

  modport slave (
    input  adc_cs, adc_op, adc_addr, res_valid, res_a, res_b, res_idx,
    output adc_rdy, adc_data, res_ready
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
`timescale 1ns/1ps
// Sequencer in front of the AD7367 interface: resets the ADC once, then runs paced conversions,
// reading channel A then B after each and handing each pair out on a valid/ready port.
module adc_sample_scheduler #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned IVL_W   = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic [IVL_W-1:0]       interval,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout,
  output logic [CNT_W-1:0]       overrun_cnt,
  adc_sample_scheduler_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StInit, StSettle, StWait, StConv, StAck, StBusy,
    StSelA, StCapA, StSelB, StCapB, StPush, StDone
  } state_e;

  localparam logic [9:0] CycLast = 10'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] ovr_q, ovr_d;
  logic [IVL_W-1:0] ivl_q, ivl_d;
  logic [IVL_W-1:0] tmr_q, tmr_d;
  logic [9:0]       cyc_q, cyc_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
  logic [13:0]      res_a_q, res_a_d;
  logic [13:0]      res_b_q, res_b_d;
  logic             running;
  logic             abort_seen;

  assign running    = (state_q != StIdle) && (state_q != StDone);
  assign abort_seen = abort_q | abort;

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    idx_d        = idx_q;
    ovr_d        = ovr_q;
    ivl_d        = ivl_q;
    cyc_d        = cyc_q;
    err_d        = err_q;
    abort_d      = abort_q;
    res_a_d      = res_a_q;
    res_b_d      = res_b_q;
    tmr_d        = (tmr_q != '0) ? tmr_q - IVL_W'(1) : tmr_q;
    bus.adc_cs   = 1'b0;
    bus.adc_op   = 4'b0000;
    bus.adc_addr = 8'h00;

    if (running && abort) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d   = num_samples;
          ivl_d   = interval;
          idx_d   = '0;
          ovr_d   = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          state_d = (num_samples == '0) ? StDone : StInit;
        end
      end
      StInit: begin
        bus.adc_cs = 1'b1;
        bus.adc_op = 4'b0001;
        cyc_d      = '0;
        state_d    = StSettle;
      end
      StSettle: begin
        cyc_d = cyc_q + 10'd1;
        if (cyc_q == 10'd1) begin
          state_d = StConv;
        end
      end
      StWait: begin
        // Timer value 1 means the next cycle is exactly on schedule; 0 means already late.
        if (abort_seen) begin
          state_d = StDone;
        end else if (tmr_q <= IVL_W'(1)) begin
          state_d = StConv;
          if (tmr_q == '0 && ovr_q != {CNT_W{1'b1}}) begin
            ovr_d = ovr_q + CNT_W'(1);
          end
        end
      end
      StConv: begin
        bus.adc_cs = 1'b1;
        bus.adc_op = 4'b0010;
        // Timer counts the CONV cycle itself, so it holds (interval - 1) from the next cycle on.
        tmr_d      = (ivl_q == '0) ? '0 : ivl_q - IVL_W'(1);
        cyc_d      = '0;
        state_d    = StAck;
      end
      StAck: begin
        cyc_d = cyc_q + 10'd1;
        if (!bus.adc_rdy) begin
          state_d = StBusy;
        end else if (cyc_q == CycLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StBusy: begin
        cyc_d = cyc_q + 10'd1;
        if (bus.adc_rdy) begin
          state_d = StSelA;
        end else if (cyc_q == CycLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StSelA: begin
        bus.adc_cs = 1'b1;
        state_d    = StCapA;
      end
      StCapA: begin
        res_a_d = bus.adc_data;
        state_d = StSelB;
      end
      StSelB: begin
        bus.adc_cs   = 1'b1;
        bus.adc_addr = 8'h01;
        state_d      = StCapB;
      end
      StCapB: begin
        res_b_d = bus.adc_data;
        state_d = StPush;
      end
      StPush: begin
        if (bus.res_ready) begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = (idx_q == num_q - CNT_W'(1) || abort_seen) ? StDone : StWait;
        end
      end
      StDone: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      num_q   <= '0;
      idx_q   <= '0;
      ovr_q   <= '0;
      ivl_q   <= '0;
      tmr_q   <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      res_a_q <= '0;
      res_b_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
      ivl_q   <= ivl_d;
      tmr_q   <= tmr_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
    end
  end

  always_comb begin
    busy          = running;
    done          = (state_q == StDone);
    err_timeout   = err_q;
    overrun_cnt   = ovr_q;
    bus.res_valid = (state_q == StPush);
    bus.res_a     = res_a_q;
    bus.res_b     = res_b_q;
    bus.res_idx   = idx_q;
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
`timescale 1ns/1ps
// Bench for adc_sample_scheduler: a behavioural ADC model, a table of run vectors and a few
// hand-written sequences for zero-length runs, ignored start/abort and asynchronous reset.
module tb_adc_sample_scheduler;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned IVL_W   = 16;
  localparam int unsigned TIMEOUT = 1023;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic [IVL_W-1:0] interval = '0;
  logic             busy;
  logic             done;
  logic             err_timeout;
  logic [CNT_W-1:0] overrun_cnt;

  adc_sample_scheduler_if #(.CNT_W(CNT_W)) bus ();

  adc_sample_scheduler #(
    .CNT_W  (CNT_W),
    .IVL_W  (IVL_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .num_samples(num_samples),
    .interval   (interval),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout),
    .overrun_cnt(overrun_cnt),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // ADC model: convert drops rdy for conv_lat cycles; a read returns the channel code next cycle.
  int unsigned conv_lat = 3;
  int          hang = 0;
  logic [13:0] code_a = 14'h1234;
  logic [13:0] code_b = 14'h0ABC;
  int unsigned lat_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.adc_rdy  <= 1'b1;
      bus.adc_data <= '0;
      lat_cnt      <= 0;
    end else begin
      if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) bus.adc_rdy <= 1'b1;
      end
      if (bus.adc_cs) begin
        if (bus.adc_op[0]) begin
          bus.adc_rdy <= 1'b1;
          lat_cnt     <= 0;
        end else if (bus.adc_op[1]) begin
          if (hang == 0) begin
            bus.adc_rdy <= 1'b0;
            lat_cnt     <= conv_lat;
          end
        end else begin
          bus.adc_data <= bus.adc_addr[0] ? code_b : code_a;
        end
      end
    end
  end

  typedef struct {
    string name;
    int    num;
    int    ivl;
    int    lat;
    int    hang;
    int    stall_pair;
    int    stall_len;
    int    abort_pair;
    int    restart_at;
    int    exp_pairs;
    int    exp_ovr;
    int    exp_gap;
    int    exp_err;
  } vec_t;

  vec_t vecs[7];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int          pairs = 0;
    int          convs = 0;
    int          cyc = 0;
    int          last_conv = -1;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          gap_bad = 0;
    int          bus_bad = 0;
    int          stall_left = 0;
    int          stall_bad = 0;
    int          extra_done = 0;
    int          busy_after = 0;
    bit          stall_started = 0;
    bit          abort_sent = 0;
    logic        prev_cs = 1'b0;
    logic [13:0] held_a = '0;
    logic [13:0] held_b = '0;
    logic [CNT_W-1:0] held_idx = '0;

    num_samples   = CNT_W'(v.num);
    interval      = IVL_W'(v.ivl);
    conv_lat      = v.lat;
    hang          = v.hang;
    bus.res_ready = 1'b1;
    start         = 1'b1;
    tick();
    start = 1'b0;
    check({v.name, " busy_on_start"}, busy, 1);
    check({v.name, " err_cleared"}, err_timeout, 0);
    check({v.name, " ovr_cleared"}, overrun_cnt, 0);
    check({v.name, " init_cmd"}, {bus.adc_cs, bus.adc_op, bus.adc_addr}, {1'b1, 4'b0001, 8'h00});

    while (done_cnt == 0 && cyc < 20000) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!bus.adc_cs && (bus.adc_op != 4'd0 || bus.adc_addr != 8'd0)) bus_bad++;
      if (bus.adc_cs && prev_cs) bus_bad++;
      prev_cs = bus.adc_cs;
      if (bus.adc_cs && bus.adc_op == 4'b0010) begin
        if (last_conv >= 0 && v.exp_gap != 0 && (cyc - last_conv) != v.exp_gap) gap_bad++;
        last_conv = cyc;
        convs++;
      end

      abort = 1'b0;
      if (v.abort_pair >= 0 && !abort_sent && convs == v.abort_pair + 1 && !bus.adc_rdy) begin
        abort      = 1'b1;
        abort_sent = 1;
      end

      if (cyc == v.restart_at) begin
        start       = 1'b1;
        num_samples = CNT_W'(9);
      end else begin
        start       = 1'b0;
        num_samples = CNT_W'(v.num);
      end

      if (bus.res_valid) begin
        if (v.stall_pair == pairs && !stall_started) begin
          stall_started = 1;
          stall_left    = v.stall_len;
          held_a        = bus.res_a;
          held_b        = bus.res_b;
          held_idx      = bus.res_idx;
          bus.res_ready = 1'b0;
        end
        if (stall_left > 0) begin
          if (bus.res_a !== held_a || bus.res_b !== held_b || bus.res_idx !== held_idx)
            stall_bad++;
          stall_left--;
          bus.res_ready = (stall_left == 0);
        end
        if (bus.res_ready) begin
          check($sformatf("%s p%0d res_a", v.name, pairs), bus.res_a, code_a);
          check($sformatf("%s p%0d res_b", v.name, pairs), bus.res_b, code_b);
          check($sformatf("%s p%0d res_idx", v.name, pairs), bus.res_idx, pairs);
          pairs++;
        end
      end
      tick();
      cyc++;
    end
    abort = 1'b0;
    start = 1'b0;

    check({v.name, " done_seen"}, done_cnt, 1);
    check({v.name, " pairs"}, pairs, v.exp_pairs);
    check({v.name, " overrun"}, overrun_cnt, v.exp_ovr);
    check({v.name, " err_timeout"}, err_timeout, v.exp_err);
    check({v.name, " conv_spacing"}, gap_bad, 0);
    check({v.name, " cs_rules"}, bus_bad, 0);
    if (v.stall_pair >= 0) check({v.name, " stall_stable"}, stall_bad, 0);
    if (v.hang != 0) check({v.name, " timeout_latency"}, done_cyc - last_conv, TIMEOUT + 1);

    for (int i = 0; i < 4; i++) begin
      if (done) extra_done++;
      if (busy) busy_after++;
      tick();
    end
    check({v.name, " single_done"}, extra_done, 0);
    check({v.name, " idle_after"}, busy_after, 0);
  endtask

  initial begin
    int n;
    int cs_cnt;
    int done_at;

    vecs[0] = '{name:"basic", num:3, ivl:100, lat:10, hang:0, stall_pair:-1, stall_len:0,
                abort_pair:-1, restart_at:-1, exp_pairs:3, exp_ovr:0, exp_gap:100, exp_err:0};
    vecs[1] = '{name:"fast", num:4, ivl:5, lat:3, hang:0, stall_pair:-1, stall_len:0,
                abort_pair:-1, restart_at:-1, exp_pairs:4, exp_ovr:3, exp_gap:11, exp_err:0};
    vecs[2] = '{name:"timeout", num:2, ivl:50, lat:3, hang:1, stall_pair:-1, stall_len:0,
                abort_pair:-1, restart_at:-1, exp_pairs:0, exp_ovr:0, exp_gap:0, exp_err:1};
    vecs[3] = '{name:"stall", num:5, ivl:20, lat:3, hang:0, stall_pair:1, stall_len:500,
                abort_pair:-1, restart_at:-1, exp_pairs:5, exp_ovr:1, exp_gap:0, exp_err:0};
    vecs[4] = '{name:"abort", num:10, ivl:30, lat:5, hang:0, stall_pair:-1, stall_len:0,
                abort_pair:2, restart_at:-1, exp_pairs:3, exp_ovr:0, exp_gap:30, exp_err:0};
    vecs[5] = '{name:"ivl0", num:3, ivl:0, lat:3, hang:0, stall_pair:-1, stall_len:0,
                abort_pair:-1, restart_at:-1, exp_pairs:3, exp_ovr:2, exp_gap:11, exp_err:0};
    vecs[6] = '{name:"restart", num:2, ivl:40, lat:3, hang:0, stall_pair:-1, stall_len:0,
                abort_pair:-1, restart_at:10, exp_pairs:2, exp_ovr:0, exp_gap:40, exp_err:0};

    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_adc_bus", {bus.adc_cs, bus.adc_op, bus.adc_addr}, 0);
    check("rst_res", {bus.res_valid, bus.res_a, bus.res_b, bus.res_idx}, 0);

    // Abort while idle must not leak into the following run.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero-length run: done without touching the ADC.
    num_samples = '0;
    start       = 1'b1;
    tick();
    start   = 1'b0;
    cs_cnt  = 0;
    done_at = -1;
    for (int i = 0; i < 6; i++) begin
      if (bus.adc_cs) cs_cnt++;
      if (done && done_at < 0) done_at = i;
      tick();
    end
    check("zero_done_at", done_at, 0);
    check("zero_no_cs", cs_cnt, 0);

    // Asynchronous reset while a pair is held on the result port.
    num_samples   = CNT_W'(5);
    interval      = IVL_W'(50);
    conv_lat      = 3;
    hang          = 0;
    bus.res_ready = 1'b0;
    start         = 1'b1;
    tick();
    start = 1'b0;
    n     = 0;
    while (!bus.res_valid && n < 200) begin
      tick();
      n++;
    end
    check("midrun_valid", bus.res_valid, 1);
    check("midrun_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {busy, done, err_timeout, overrun_cnt}, 0);
    check("async_rst_res", {bus.res_valid, bus.res_a, bus.res_b, bus.res_idx}, 0);
    check("async_rst_adc", {bus.adc_cs, bus.adc_op, bus.adc_addr}, 0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    check("post_rst_idle", {busy, bus.res_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
